// File: rtl/alu_issue_sched_pkg.sv
// -----------------------------------------------------------------------------
// typedefs: types shared by the OoO core's execute path.
//   aluStruct     - operands and operation for the single-cycle ALU.
//   aluReqStruct  - one requester's op plus its destination ROB tag.
//   TAG_W_DEF     - default ROB tag width.
// The all-zero aluStruct encodes AND 0,0, which the scheduler drives as its
// idle value.
// -----------------------------------------------------------------------------
package typedefs;

  localparam int TAG_W_DEF = 6;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_XOR = 3'd2,
    ALU_ADD = 3'd3,
    ALU_SUB = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  typedef struct packed {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
  } aluStruct;

  // The tag field is sized for the widest tag the core uses. Narrower
  // schedulers zero-extend into it.
  typedef struct packed {
    aluStruct               op;
    logic [TAG_W_DEF-1:0]   tag;
  } aluReqStruct;

endpackage

// File: rtl/alu_issue_sched_if.sv
// -----------------------------------------------------------------------------
// alu_issue_sched_if: every signal between the issue scheduler and its
// neighbours. These are the reservation-station requesters, the shared ALU and
// the common data bus.
//   slave  - the scheduler side.
//   master - the environment side (requesters, ALU, CDB arbiter, flush source).
// Signals:
//   flush                     pipeline flush, synchronous
//   req_valid/req_op/req_tag  per-requester ready op
//   req_ready                 one-hot grant
//   alu_in / alu_result       ALU input, and its result registered one cycle later
//   cdb_valid/tag/data        result presented on the CDB
//   cdb_ready                 CDB accepts this cycle
// -----------------------------------------------------------------------------
interface alu_issue_sched_if
  import typedefs::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = TAG_W_DEF
) ();

  logic                            flush;
  logic [NUM_REQ-1:0]              req_valid;
  aluStruct [NUM_REQ-1:0]          req_op;
  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag;
  logic [NUM_REQ-1:0]              req_ready;
  aluStruct                        alu_in;
  logic [31:0]                     alu_result;
  logic                            cdb_valid;
  logic [TAG_W-1:0]                cdb_tag;
  logic [31:0]                     cdb_data;
  logic                            cdb_ready;

  modport slave (
    input  flush, req_valid, req_op, req_tag, alu_result, cdb_ready,
    output req_ready, alu_in, cdb_valid, cdb_tag, cdb_data
  );

  modport master (
    output flush, req_valid, req_op, req_tag, alu_result, cdb_ready,
    input  req_ready, alu_in, cdb_valid, cdb_tag, cdb_data
  );

endinterface

// File: rtl/alu_issue_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter: N-way round-robin arbiter that holds its own priority pointer.
//   clk, rst  clock, asynchronous active-high reset (ptr -> 0)
//   req[N]    request vector
//   en        grant enable; with en low gnt is zero and ptr holds
//   gnt[N]    one-hot (or zero) grant. It is combinational from req/en/ptr.
// The search starts at ptr and wraps modulo N. After a grant to index i, ptr
// moves to (i+1) mod N.
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  typedef logic [PTR_W-1:0] idx_t;

  idx_t ptr;
  idx_t ptr_nxt;
  idx_t idx;
  logic found;

  // Modulo-N increment. It also works when N is not a power of two.
  function automatic idx_t wrap_inc(input idx_t i);
    return (i == idx_t'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  // NOTE: every variable gets a default before the search loop, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    idx     = ptr;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        ptr_nxt  = wrap_inc(idx);
        found    = 1'b1;
      end
      idx = wrap_inc(idx);
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end

endmodule

// File: rtl/alu_issue_sched.sv
// -----------------------------------------------------------------------------
// alu_issue_sched: shares one registered ALU among NUM_REQ reservation-station
// requesters.
//   clk  clock shared with the ALU
//   rst  asynchronous, active-high reset
//   bus  alu_issue_sched_if.slave. It carries the requester handshake, the
//        ALU in/out, the CDB handshake and flush.
// Each cycle at most one ready requester is granted, round-robin. Its op goes
// to the ALU, and its tag follows the ALU register stage in s1_tag. The result
// appears on the CDB one cycle after the grant. If the CDB stalls, the result
// moves into a one-entry hold buffer before the ALU register is overwritten.
// TAG_W must not exceed TAG_W_DEF, because the grant mux carries the tag in an
// aluReqStruct.
// -----------------------------------------------------------------------------
module alu_issue_sched
  import typedefs::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_sched_if.slave   bus
);

  logic [NUM_REQ-1:0] gnt;
  logic               issue_en;
  aluReqStruct        sel;

  logic               s1_valid;
  logic [TAG_W-1:0]   s1_tag;
  logic               hold_valid;
  logic [TAG_W-1:0]   hold_tag;
  logic [31:0]        hold_data;

  // A new op may enter the ALU only if its result is guaranteed a home next
  // cycle. That holds when the CDB takes whatever is shown now, or when
  // nothing is shown at all. Nothing issues during flush or reset.
  assign issue_en = !rst && !bus.flush &&
                    (bus.cdb_ready || (!hold_valid && !s1_valid));

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.req_valid),
    .en  (issue_en),
    .gnt (gnt)
  );

  assign bus.req_ready = gnt;

  // Grant mux. gnt is one-hot, so at most one term fires. With no grant the
  // ALU sees all zeros, which is AND 0,0, and its result is ignored.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel.op  = bus.req_op[i];
        sel.tag = TAG_W_DEF'(bus.req_tag[i]);
      end
    end
  end

  assign bus.alu_in = sel.op;

  // Execute stage: this register tracks the op that is now inside the ALU
  // register. A flush needs no special case, because issue_en already blocks
  // the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= |gnt;
      s1_tag   <= TAG_W'(sel.tag);
    end
  end

  // Skid buffer. It captures a stalled ALU result, because the ALU register
  // is rewritten every cycle. No new op is granted while the stall lasts, so
  // hold_valid and s1_valid are never both set.
  // NOTE: hold_data is datapath, but it is reset with the rest of the buffer
  // so that it has a defined value after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_tag   <= '0;
      hold_data  <= '0;
    end else if (bus.flush) begin
      hold_valid <= 1'b0;
    end else if (s1_valid && !hold_valid && !bus.cdb_ready) begin
      hold_valid <= 1'b1;
      hold_tag   <= s1_tag;
      hold_data  <= bus.alu_result;
    end else if (hold_valid && bus.cdb_ready) begin
      hold_valid <= 1'b0;
    end
  end

  // CDB source: the hold buffer has priority, because it is always the older
  // result.
  assign bus.cdb_valid = hold_valid || s1_valid;
  assign bus.cdb_tag   = hold_valid ? hold_tag  : s1_tag;
  assign bus.cdb_data  = hold_valid ? hold_data : bus.alu_result;

endmodule

// File: tb/tb_alu_issue_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_sched: self-checking bench for alu_issue_sched. It contains a
// behavioural registered ALU, table-driven single-op vectors, hand-written
// sequences for fairness, back-pressure, flush and async reset, and a
// randomised run. A scoreboard checks that every granted tag reaches the CDB
// exactly once and in grant order.
// -----------------------------------------------------------------------------
module tb_alu_issue_sched;
  import typedefs::*;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_sched_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

  alu_issue_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] alu_f(input aluStruct s);
    case (s.op)
      ALU_AND: return s.a & s.b;
      ALU_OR:  return s.a | s.b;
      ALU_XOR: return s.a ^ s.b;
      ALU_ADD: return s.a + s.b;
      ALU_SUB: return s.a - s.b;
      ALU_SLL: return s.a << s.b[4:0];
      ALU_SRL: return s.a >> s.b[4:0];
      default: return {31'd0, $signed(s.a) < $signed(s.b)};
    endcase
  endfunction

  // Behavioural ALU: result registered one cycle after alu_in.
  always @(posedge clk) bus.alu_result <= alu_f(bus.alu_in);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } sb_t;
  sb_t sbq[$];

  always @(negedge clk) begin : mon
    sb_t e;
    if (rst) begin
      sbq.delete();
    end else begin
      if (bus.cdb_valid && bus.cdb_ready) begin
        check("sb_pending", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("sb_tag",  bus.cdb_tag,  e.tag);
          check("sb_data", bus.cdb_data, e.data);
        end
      end
      if (bus.flush) sbq.delete();
      else
        for (int i = 0; i < NUM_REQ; i++)
          if (bus.req_valid[i] && bus.req_ready[i])
            sbq.push_back('{bus.req_tag[i], alu_f(bus.req_op[i])});
      check("inv_hold_s1", 64'(dut.hold_valid && dut.s1_valid), 64'd0);
    end
  end

  // ------------------------------------------------------------------- helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input alu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
    bus.req_op[i]  = '{op: op, a: a, b: b};
    bus.req_tag[i] = tag;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.flush     = 1'b0;
    bus.cdb_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // ------------------------------------------------------------- vector table
  typedef struct {
    logic [3:0]       valid;
    alu_op_e          op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;        // requester i gets tag+i
    logic [3:0]       exp_ready;
    logic             exp_cv;
    logic [TAG_W-1:0] exp_tag;
    logic [31:0]      exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [3:0] e_gnt;

    vecs[0] = '{4'b0001, ALU_ADD, 32'd3,        32'd4,      6'd5,  4'b0001, 1'b1, 6'd5,  32'd7};
    vecs[1] = '{4'b0011, ALU_SUB, 32'd10,       32'd3,      6'd8,  4'b0010, 1'b1, 6'd9,  32'd7};
    vecs[2] = '{4'b0001, ALU_AND, 32'hff0f,     32'h0ff0,   6'd20, 4'b0001, 1'b1, 6'd20, 32'h0f00};
    vecs[3] = '{4'b1100, ALU_OR,  32'hf0,       32'h0f,     6'd30, 4'b0100, 1'b1, 6'd32, 32'hff};
    vecs[4] = '{4'b1001, ALU_XOR, 32'hff,       32'h0f,     6'd40, 4'b1000, 1'b1, 6'd43, 32'hf0};
    vecs[5] = '{4'b1111, ALU_ADD, 32'hffffffff, 32'd1,      6'd50, 4'b0001, 1'b1, 6'd50, 32'd0};
    vecs[6] = '{4'b0000, ALU_ADD, 32'd1,        32'd1,      6'd60, 4'b0000, 1'b0, 6'd0,  32'd0};

    bus.flush     = 1'b0;
    bus.cdb_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, ALU_ADD, 32'd0, 32'd0, TAG_W'(i));

    // Reset state: no grant and no result, even with requests present.
    cyc();
    mid();
    check("rst_ready",     bus.req_ready, 4'b0000);
    check("rst_cdb_valid", bus.cdb_valid, 1'b0);
    check("rst_cdb_tag",   bus.cdb_tag,   6'd0);
    cyc();
    bus.req_valid = '0;
    rst = 1'b0;
    mid();
    check("post_rst_cdb_valid", bus.cdb_valid, 1'b0);
    check("post_rst_ready",     bus.req_ready, 4'b0000);

    // Table: one op per vector, then an idle cycle while the result shows.
    for (int k = 0; k < 7; k++) begin
      cyc();
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, vecs[k].op, vecs[k].a, vecs[k].b, TAG_W'(vecs[k].tag + TAG_W'(i)));
      bus.req_valid = vecs[k].valid;
      bus.cdb_ready = 1'b1;
      mid();
      check($sformatf("vec%0d_ready", k), bus.req_ready, vecs[k].exp_ready);
      cyc();
      bus.req_valid = '0;
      mid();
      check($sformatf("vec%0d_cdb_valid", k), bus.cdb_valid, vecs[k].exp_cv);
      if (vecs[k].exp_cv) begin
        check($sformatf("vec%0d_cdb_tag", k),  bus.cdb_tag,  vecs[k].exp_tag);
        check($sformatf("vec%0d_cdb_data", k), bus.cdb_data, vecs[k].exp_data);
      end
    end

    // Fairness: all requesters valid from ptr=0, so grants go 0,1,2,3,0,1.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, ALU_ADD, 32'(i), 32'd100, TAG_W'(10 + i));
    bus.req_valid = 4'b1111;
    bus.cdb_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) cyc();
      mid();
      e_gnt = 4'(1 << (c % 4));
      check($sformatf("fair_gnt%0d", c), bus.req_ready, e_gnt);
    end
    cyc();
    bus.req_valid = '0;
    mid();
    cyc();
    mid();

    // Back-pressure: tag 9 (10-3) is granted at T, and the CDB stalls T+1..T+3.
    cyc();
    set_req(0, ALU_SUB, 32'd10, 32'd3, 6'd9);
    bus.req_valid = 4'b0001;
    bus.cdb_ready = 1'b1;
    mid();
    check("bp_grant", bus.req_ready, 4'b0001);
    cyc();
    set_req(0, ALU_ADD, 32'd1, 32'd1, 6'd10);
    bus.cdb_ready = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      if (j > 1) cyc();
      mid();
      check($sformatf("bp_cv_t%0d", j),    bus.cdb_valid, 1'b1);
      check($sformatf("bp_tag_t%0d", j),   bus.cdb_tag,   6'd9);
      check($sformatf("bp_data_t%0d", j),  bus.cdb_data,  32'd7);
      check($sformatf("bp_ready_t%0d", j), bus.req_ready, 4'b0000);
    end
    cyc();
    bus.cdb_ready = 1'b1;
    mid();
    check("bp_drain_tag",  bus.cdb_tag,   6'd9);
    check("bp_drain_data", bus.cdb_data,  32'd7);
    check("bp_drain_gnt",  bus.req_ready, 4'b0001);
    cyc();
    bus.req_valid = '0;
    mid();
    check("bp_next_tag",  bus.cdb_tag,  6'd10);
    check("bp_next_data", bus.cdb_data, 32'd2);
    cyc();
    mid();
    check("bp_idle", bus.cdb_valid, 1'b0);

    // Flush: grant tag 2 at T (ptr becomes 3), flush at T+1 with the CDB stalled.
    cyc();
    set_req(2, ALU_ADD, 32'd1, 32'd2, 6'd2);
    bus.req_valid = 4'b0100;
    mid();
    check("fl_grant", bus.req_ready, 4'b0100);
    cyc();
    set_req(0, ALU_ADD, 32'd5, 32'd5, 6'd11);
    bus.req_valid = 4'b0001;
    bus.flush     = 1'b1;
    bus.cdb_ready = 1'b0;
    mid();
    check("fl_no_grant",  bus.req_ready, 4'b0000);
    check("fl_cv_before", bus.cdb_valid, 1'b1);
    cyc();
    bus.flush     = 1'b0;
    bus.req_valid = '0;
    mid();
    check("fl_cv_cleared", bus.cdb_valid, 1'b0);
    cyc();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, ALU_OR, 32'(i), 32'h100, TAG_W'(12 + i));
    bus.req_valid = 4'b1111;
    bus.cdb_ready = 1'b1;
    mid();
    check("fl_ptr_kept", bus.req_ready, 4'b1000);
    cyc();
    bus.req_valid = '0;
    mid();
    cyc();
    mid();

    // Async reset while the hold buffer is full. Grant req1 first, so a
    // pointer that survived reset would be visible afterwards.
    cyc();
    set_req(1, ALU_ADD, 32'd5, 32'd6, 6'd21);
    bus.req_valid = 4'b0010;
    bus.cdb_ready = 1'b1;
    mid();
    check("ar_grant", bus.req_ready, 4'b0010);
    cyc();
    bus.req_valid = '0;
    bus.cdb_ready = 1'b0;
    mid();
    cyc();
    mid();
    check("ar_pre_cv",   bus.cdb_valid, 1'b1);
    check("ar_pre_tag",  bus.cdb_tag,   6'd21);
    check("ar_pre_data", bus.cdb_data,  32'd11);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("ar_cv_killed",  bus.cdb_valid, 1'b0);
    check("ar_tag_killed", bus.cdb_tag,   6'd0);
    cyc();
    cyc();
    rst = 1'b0;
    set_req(1, ALU_ADD, 32'd7, 32'd8, 6'd22);
    set_req(2, ALU_ADD, 32'd9, 32'd9, 6'd23);
    bus.req_valid = 4'b0110;
    bus.cdb_ready = 1'b1;
    mid();
    check("ar_post_cv",  bus.cdb_valid, 1'b0);
    check("ar_post_gnt", bus.req_ready, 4'b0010);
    cyc();
    bus.req_valid = '0;
    mid();
    check("ar_post_tag",  bus.cdb_tag,  6'd22);
    check("ar_post_data", bus.cdb_data, 32'd15);

    // Random traffic. The scoreboard and the invariant check run every cycle.
    for (int n = 0; n < 10000; n++) begin
      cyc();
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, alu_op_e'($urandom_range(0, 7)), $urandom, $urandom, TAG_W'($urandom));
      bus.req_valid = 4'($urandom);
      bus.cdb_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 63) == 0);
      mid();
      check("rnd_onehot", 64'($onehot0(bus.req_ready)), 64'd1);
      check("rnd_subset", bus.req_ready & ~bus.req_valid, 4'b0000);
      if (bus.flush) check("rnd_flush_no_grant", bus.req_ready, 4'b0000);
    end

    // Drain, then confirm that every granted tag came out.
    cyc();
    bus.req_valid = '0;
    bus.flush     = 1'b0;
    bus.cdb_ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      mid();
      cyc();
    end
    mid();
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
